uart_rx: RTL and testbench

- UART receiver paired with uart_tx in the AES UART IP core.
- Deserialises rxd using an 8x-oversampling baud_clk pulse and the same runtime frame configuration as uart_tx: data bits, parity and stop bits.
- Delivers each good character on an AXI-Stream master interface.
- Reports parity, framing and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// AXI-Stream bundle for the AES UART IP core.
// Carries tdata/tvalid from the master and tready back from the slave.
interface taxi_axis_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled, majority-voted, runtime frame format.
// Ports: Clk/Rst_n/En control, baud_clk tick, rxd line, frame config
//   (data_bits, stop_bits, parity_en, parity_type), m_axis character
//   stream, busy status and rx_done/parity/frame/overrun pulses.
module uart_rx #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        En,
    input  logic        baud_clk,
    input  logic        rxd,
    taxi_axis_if.master m_axis,
    input  logic [1:0]  data_bits,
    input  logic [1:0]  stop_bits,
    input  logic        parity_en,
    input  logic        parity_type,
    output logic        busy,
    output logic        rx_done,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun_err
);
    localparam logic [2:0] T_LAST = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] T_MID  = 3'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0] T_HALF = 3'(OVERSAMPLE * 3 / 4);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, STOP2, WAIT_HIGH
    } state_t;

    state_t state, state_n;

    logic              rx_s1, rx_s2;
    logic [2:0]        tick_cnt, tick_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, sh_n;
    logic              s0, s0_n, s1, s1_n;
    logic              perr_f, perr_n, ferr_f, ferr_n;
    logic [1:0]        cfg_dbits, dbits_n;
    logic [1:0]        cfg_stop, stop_n;
    logic              cfg_pen, pen_n, cfg_ptype, ptype_n;
    logic              tvalid_q, tvalid_n;
    logic [DATA_W-1:0] tdata_q, tdata_n;
    logic              done_n, perr_p, ferr_p, ovr_p;
    logic              fin, fin_bad;
    logic [2:0]        t, smp, s2_last, last_bit;
    logic              vote, exp_par, mid, last;

    assign busy = (state != IDLE) && (state != WAIT_HIGH);

    // The tick counter wraps every bit, so a whole extra bit of
    // stop time lands back on the mid tick.
    assign s2_last  = (cfg_stop == 2'd1) ? T_MID + T_HALF : T_MID;
    assign smp      = (state == STOP2) ? s2_last : T_MID;
    assign t        = tick_cnt + 3'd1;
    assign mid      = baud_clk && busy && (t == smp);
    assign last     = baud_clk && busy && (t == T_LAST);
    assign vote     = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
    assign last_bit = 3'd7 - {1'b0, cfg_dbits};
    assign exp_par  = (^(shreg >> cfg_dbits)) ^ cfg_ptype;

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n || !En) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        sh_n     = shreg;
        s0_n     = s0;
        s1_n     = s1;
        perr_n   = perr_f;
        ferr_n   = ferr_f;
        dbits_n  = cfg_dbits;
        stop_n   = cfg_stop;
        pen_n    = cfg_pen;
        ptype_n  = cfg_ptype;
        tvalid_n = tvalid_q;
        tdata_n  = tdata_q;
        done_n   = 1'b0;
        perr_p   = 1'b0;
        ferr_p   = 1'b0;
        ovr_p    = 1'b0;
        fin      = 1'b0;
        fin_bad  = 1'b0;

        if (tvalid_q && m_axis.tready) begin
            tvalid_n = 1'b0;
        end

        // Detection tick is tick 0; later ticks advance the counter.
        if (baud_clk && busy) begin
            tick_n = t;
            if (t == smp - 3'd2) s0_n = rx_s2;
            if (t == smp - 3'd1) s1_n = rx_s2;
        end

        unique case (state)
            IDLE: begin
                if (baud_clk && !rx_s2) begin
                    state_n = START;
                    tick_n  = 3'd0;
                    bit_n   = 3'd0;
                    sh_n    = 8'd0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    dbits_n = data_bits;
                    stop_n  = stop_bits;
                    pen_n   = parity_en;
                    ptype_n = parity_type;
                end
            end
            START: begin
                if (mid && vote) begin
                    state_n = IDLE;
                    tick_n  = 3'd0;
                end else if (last) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (mid) sh_n = {vote, shreg[7:1]};
                if (last) begin
                    if (bit_cnt == last_bit) begin
                        state_n = cfg_pen ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (mid && (vote != exp_par)) perr_n = 1'b1;
                if (last) state_n = STOP;
            end
            STOP: begin
                if (mid) begin
                    if (cfg_stop == 2'd0) begin
                        fin     = 1'b1;
                        fin_bad = !vote;
                    end else begin
                        ferr_n  = !vote;
                        state_n = STOP2;
                    end
                end
            end
            STOP2: begin
                if (mid) begin
                    fin     = 1'b1;
                    fin_bad = ferr_f || !vote;
                end
            end
            WAIT_HIGH: begin
                if (baud_clk && rx_s2) state_n = IDLE;
            end
        endcase

        if (fin) begin
            done_n  = 1'b1;
            tick_n  = 3'd0;
            bit_n   = 3'd0;
            state_n = fin_bad ? WAIT_HIGH : IDLE;
            if (fin_bad) begin
                ferr_p = 1'b1;
            end else if (perr_f) begin
                perr_p = 1'b1;
            end else if (tvalid_q && !m_axis.tready) begin
                ovr_p = 1'b1;
            end else begin
                tvalid_n = 1'b1;
                tdata_n  = DATA_W'(shreg >> cfg_dbits);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            tick_cnt    <= 3'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            perr_f      <= 1'b0;
            ferr_f      <= 1'b0;
            cfg_dbits   <= 2'd0;
            cfg_stop    <= 2'd0;
            cfg_pen     <= 1'b0;
            cfg_ptype   <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            rx_done     <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            if (!En) begin
                tick_cnt    <= 3'd0;
                bit_cnt     <= 3'd0;
                tvalid_q    <= tvalid_q && !m_axis.tready;
                rx_done     <= 1'b0;
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end else begin
                tick_cnt    <= tick_n;
                bit_cnt     <= bit_n;
                shreg       <= sh_n;
                s0          <= s0_n;
                s1          <= s1_n;
                perr_f      <= perr_n;
                ferr_f      <= ferr_n;
                cfg_dbits   <= dbits_n;
                cfg_stop    <= stop_n;
                cfg_pen     <= pen_n;
                cfg_ptype   <= ptype_n;
                tvalid_q    <= tvalid_n;
                tdata_q     <= tdata_n;
                rx_done     <= done_n;
                parity_err  <= perr_p;
                frame_err   <= ferr_p;
                overrun_err <= ovr_p;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed and random frames.
// Expected outcomes come from a frame-level model in the driver.
module tb_uart_rx;
    localparam int BIT = 64;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       En = 1'b1;
    logic       baud_clk = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] data_bits = 2'd0;
    logic [1:0] stop_bits = 2'd0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       busy, rx_done, parity_err, frame_err, overrun_err;
    logic [2:0] bcnt = 3'd0;

    taxi_axis_if #(.DATA_W(8)) axis ();

    uart_rx dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .En          (En),
        .baud_clk    (baud_clk),
        .rxd         (rxd),
        .m_axis      (axis),
        .data_bits   (data_bits),
        .stop_bits   (stop_bits),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .busy        (busy),
        .rx_done     (rx_done),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        bcnt     <= bcnt + 3'd1;
        baud_clk <= (bcnt == 3'd6);
    end

    // outcome codes: 0 good, 1 parity, 2 framing, 3 overrun
    int         ev_q[$];
    logic [7:0] beat_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ev;
    logic [2:0] act, want;
    logic [7:0] eb;

    task automatic check(input string name, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, a, e);
        end
    endtask

    always @(negedge Clk) begin
        #1;
        if (Rst_n) begin
            act = {parity_err, frame_err, overrun_err};
            if (rx_done) begin
                checks++;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done flags=%b", act);
                end else begin
                    ev = ev_q.pop_front();
                    want = (ev == 1) ? 3'b100 :
                           (ev == 2) ? 3'b010 :
                           (ev == 3) ? 3'b001 : 3'b000;
                    if (act !== want) begin
                        errors++;
                        $display("FAIL done_flags got=%b want=%b", act, want);
                    end
                end
            end else if (act != 3'b000) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse flags=%b", act);
            end
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%0h", axis.tdata);
                end else begin
                    eb = beat_q.pop_front();
                    if (axis.tdata !== eb) begin
                        errors++;
                        $display("FAIL beat_data got=%0h want=%0h",
                                 axis.tdata, eb);
                    end
                end
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        rxd = lvl;
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input logic pen, input logic ptype,
                              input logic [1:0] sb, input logic flip,
                              input logic st1_low, input logic st2_low);
        logic [7:0] m;
        logic       pbit;
        logic       fe;
        logic       last_low;
        m        = d & 8'((1 << nb) - 1);
        pbit     = logic'($countones(m) % 2) ^ ptype ^ flip;
        fe       = st1_low || (sb != 2'd0 && st2_low);
        last_low = (sb == 2'd0) ? st1_low : st2_low;
        data_bits   = 2'(8 - nb);
        stop_bits   = sb;
        parity_en   = pen;
        parity_type = ptype;
        if (fe) begin
            ev_q.push_back(2);
        end else if (pen && flip) begin
            ev_q.push_back(1);
        end else if (beat_q.size() != 0 && !axis.tready) begin
            ev_q.push_back(3);
        end else begin
            ev_q.push_back(0);
            beat_q.push_back(m);
        end
        hold(1'b0, BIT);
        for (int i = 0; i < nb; i++) hold(m[i], BIT);
        if (pen) hold(pbit, BIT);
        hold(!st1_low, BIT);
        if (sb == 2'd1) hold(!st2_low, BIT / 2);
        else if (sb != 2'd0) hold(!st2_low, BIT);
        if (last_low) begin
            hold(1'b0, BIT);
            check("busy_wait_high", busy, 0);
        end
        hold(1'b1, 2 * BIT);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        axis.tready = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", rx_done, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_errs", {parity_err, frame_err, overrun_err}, 0);
        Rst_n = 1'b1;
        hold(1'b1, BIT);

        send_frame(8'h5A, 8, 0, 0, 2'd0, 0, 0, 0);
        send_frame(8'h5A, 8, 1, 1, 2'd0, 0, 0, 0);
        send_frame(8'h5A, 8, 1, 0, 2'd0, 0, 0, 0);
        send_frame(8'h5A, 8, 1, 1, 2'd0, 1, 0, 0);
        send_frame(8'h5A, 8, 1, 0, 2'd0, 1, 0, 0);
        check("perr_no_beat", axis.tvalid, 0);

        send_frame(8'h35, 7, 0, 0, 2'd2, 0, 1, 1);
        send_frame(8'h15, 5, 0, 0, 2'd1, 0, 0, 0);

        // glitch: short low pulse must be rejected as a false start
        hold(1'b0, 16);
        check("glitch_busy_hi", busy, 1);
        hold(1'b1, BIT);
        check("glitch_busy_lo", busy, 0);
        hold(1'b1, BIT);

        axis.tready = 1'b0;
        send_frame(8'h11, 8, 0, 0, 2'd0, 0, 0, 0);
        send_frame(8'h22, 8, 0, 0, 2'd0, 0, 0, 0);
        check("ovr_tvalid", axis.tvalid, 1);
        check("ovr_tdata", axis.tdata, beat_q[0]);
        hold(1'b1, BIT);
        check("ovr_tdata_held", axis.tdata, beat_q[0]);
        axis.tready = 1'b1;
        hold(1'b1, 4);
        check("ovr_drained", axis.tvalid, 0);

        // reset in the middle of the data bits
        data_bits = 2'd0;
        parity_en = 1'b0;
        stop_bits = 2'd0;
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT + BIT / 2);
        check("rst_mid_busy", busy, 1);
        Rst_n = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst_mid_idle", busy, 0);
        check("rst_mid_tvalid", axis.tvalid, 0);
        Rst_n = 1'b1;
        hold(1'b1, 2 * BIT);
        send_frame(8'hA5, 8, 0, 0, 2'd0, 0, 0, 0);

        // enable dropped in the middle of the data bits
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT + BIT / 2);
        check("en_mid_busy", busy, 1);
        En = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge Clk);
        check("en_mid_idle", busy, 0);
        hold(1'b1, BIT);
        En = 1'b1;
        hold(1'b1, BIT);
        send_frame(8'hA5, 8, 0, 0, 2'd0, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            send_frame(8'($urandom), 5 + int'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom),
                       2'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 5) == 0));
        end

        hold(1'b1, BIT);
        check("events_left", ev_q.size(), 0);
        check("beats_left", beat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
